// File: rtl/aes_encrypt_ctrl.sv
// aes_encrypt_ctrl: iterative AES-128 encryption sequencer; define AES_KEY_CACHE_EN to skip the key wait on a repeated key
module aes_encrypt_ctrl #(
  parameter int KEY_LAT = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  key,
  input  logic [127:0]  plain_text,
  output logic [127:0]  key_q,
  input  logic [1407:0] expanded_key,
  output logic [127:0]  round_in,
  output logic [127:0]  round_key,
  output logic          last_round,
  input  logic [127:0]  round_out,
  output logic [3:0]    round_idx,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  cypher_text
);
  typedef enum logic [2:0] {IDLE, KEYWAIT, INIT, ROUND, DONE} state_t;
  state_t       state;
  logic [5:0]   cnt;
  logic [127:0] pt_q;
  logic [127:0] st_q;
  logic [127:0] rk [16];
  logic         go_init;
  for (genvar r = 0; r < 16; r++) begin : g_rk
    if (r < 11) begin : g_v
      assign rk[r] = expanded_key[1407-128*r -: 128];
    end else begin : g_z
      assign rk[r] = '0;
    end
  end
`ifdef AES_KEY_CACHE_EN
  logic cache_valid;
  assign go_init = cache_valid && key == key_q;
  // the schedule for key_q stays valid once it has been used by an INIT
  always_ff @(posedge clk)
    if (rst) cache_valid <= 1'b0;
    else if (state == INIT) cache_valid <= 1'b1;
`else
  assign go_init = 1'b0;
`endif
  assign in_ready    = state == IDLE;
  assign busy        = state != IDLE;
  assign out_valid   = state == DONE;
  assign cypher_text = st_q;
  assign round_in    = st_q;
  assign round_key   = rk[round_idx];
  assign last_round  = round_idx == 4'd10;
  // sequencer: accept, wait for the key schedule, whiten, run ten rounds, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      key_q     <= '0;
      pt_q      <= '0;
      st_q      <= '0;
      round_idx <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          key_q     <= key;
          pt_q      <= plain_text;
          cnt       <= 6'(KEY_LAT);
          round_idx <= '0;
          state     <= go_init ? INIT : KEYWAIT;
        end
        KEYWAIT: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= INIT;
        end
        INIT: begin
          st_q      <= pt_q ^ rk[0];
          round_idx <= 4'd1;
          state     <= ROUND;
        end
        ROUND: begin
          st_q <= round_out;
          if (round_idx == 4'd10) state <= DONE;
          else round_idx <= round_idx + 4'd1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// tb_aes_encrypt_ctrl: directed bench with a behavioural key schedule (KEY_LAT pipeline) and round unit
module tb_aes_encrypt_ctrl;
  localparam int KL = 10;
  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_KEY_CACHE_EN
  localparam int CACHED_LAT = 12;
`else
  localparam int CACHED_LAT = 22;
`endif
  logic          clk, rst, in_valid, in_ready, last_round, busy, out_valid, out_ready;
  logic [127:0]  key, plain_text, key_q, round_in, round_key, round_out, cypher_text;
  logic [1407:0] expanded_key;
  logic [3:0]    round_idx;
  logic [7:0]    sbox [256];
  logic [1407:0] kpipe [KL];
  int total = 0;
  int bad = 0;

  aes_encrypt_ctrl #(.KEY_LAT(KL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key(key),
    .plain_text(plain_text), .key_q(key_q), .expanded_key(expanded_key),
    .round_in(round_in), .round_key(round_key), .last_round(last_round),
    .round_out(round_out), .round_idx(round_idx), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .cypher_text(cypher_text)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] e;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) e[1407-32*i -: 32] = w[i];
    return e;
  endfunction

  // key schedule becomes valid exactly KEY_LAT cycles after key_q changes
  always @(posedge clk) begin
    kpipe[0] <= expand(key_q);
    for (int i = 1; i < KL; i++) kpipe[i] <= kpipe[i-1];
  end
  assign expanded_key = kpipe[KL-1];
  assign round_out = aes_round(round_in, round_key, last_round);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    key = k;
    plain_text = p;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n0, input int lat, input logic [127:0] ct);
    int n;
    n = n0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 80);
    chk({tag, "_lat"}, 128'(n), 128'(lat));
    chk({tag, "_ct"}, cypher_text, ct);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_idle_out_valid"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    int n;
    int exp_idx;
    int seen;
    logic [127:0] held;
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++) if (gm(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    key = '0;
    plain_text = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_round_idx", 128'(round_idx), 128'(0));
    chk("rst_key_q", key_q, 128'(0));
    chk("rst_ct", cypher_text, 128'(0));
    send("c1", C1K, C1P);
    wait_done("c1", 0, 22, C1C);
    check_idle("c1");
    send("b", BK, BP);
    for (n = 1; n <= KL + 11; n++) begin
      @(negedge clk);
      exp_idx = n <= KL + 1 ? 0 : n - KL - 1;
      chk($sformatf("b_idx_c%0d", n), 128'(round_idx), 128'(exp_idx));
      chk($sformatf("b_last_c%0d", n), 128'(last_round), 128'(exp_idx == 10));
      chk($sformatf("b_busy_c%0d", n), 128'(busy), 128'(1));
    end
    wait_done("b", KL + 11, 22, BC);
    check_idle("b");
    out_ready = 1'b0;
    send("bp", BK, BP);
    repeat (15) @(negedge clk);
    in_valid = 1'b1;
    key = C1K;
    plain_text = C1P;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("bp", 16, 22, BC);
    held = cypher_text;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_hold_ct", cypher_text, held);
      chk("bp_hold_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_idle("bp");
    send("abort", BK, BP);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (round_idx != 4'd5 && n < 40);
    chk("abort_reach_r5", 128'(round_idx), 128'(5));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_round_idx", 128'(round_idx), 128'(0));
    chk("abort_key_q", key_q, 128'(0));
    chk("abort_state_reg", round_in, 128'(0));
    chk("abort_ct", cypher_text, 128'(0));
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_result", 128'(seen), 128'(0));
    send("c1b", C1K, C1P);
    wait_done("c1b", 0, 22, C1C);
    check_idle("c1b");
    send("c1c", C1K, C1P);
    wait_done("c1c", 0, CACHED_LAT, C1C);
    check_idle("c1c");
    send("bnew", BK, BP);
    wait_done("bnew", 0, 22, BC);
    check_idle("bnew");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
